// File: rtl/ci_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ci_dispatch_pkg
// Description : Shared state encoding and constants for the CI dispatch block.
// Revision    : 1.0 - initial release
// ============================================================================
package ci_dispatch_pkg;

  localparam int          CI_ID_W       = 8;
  localparam logic [31:0] CI_ERR_RESULT = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ci_id_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ci_id_decoder
// Description : Priority match of a CI id against the packed per-unit id table.
// Revision    : 1.0 - initial release
// ============================================================================
module ci_id_decoder
  import ci_dispatch_pkg::*;
#(
  parameter int                     NR_UNITS = 4,
  parameter logic [8*NR_UNITS-1:0]  UNIT_IDS = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter int                     SEL_W    = (NR_UNITS > 1) ? $clog2(NR_UNITS) : 1
) (
  input  logic [CI_ID_W-1:0] i_ci_n,
  output logic               o_hit,
  output logic [SEL_W-1:0]   o_sel
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    for (int k = NR_UNITS - 1; k >= 0; k--) begin
      if (UNIT_IDS[8*k +: 8] == i_ci_n) begin
        o_hit = 1'b1;
        o_sel = SEL_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ci_dispatch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ci_dispatch_sequencer
// Description : Dispatches CPU custom-instruction requests to CI units and
//               returns a one-cycle done/result, with error on miss or hang.
// Revision    : 1.0 - initial release
// ============================================================================
module ci_dispatch_sequencer
  import ci_dispatch_pkg::*;
#(
  parameter int                     NR_UNITS       = 4,
  parameter logic [8*NR_UNITS-1:0]  UNIT_IDS       = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter int                     TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ciStart,
  input  logic [CI_ID_W-1:0]       ciN,
  input  logic [31:0]              ciValueA,
  input  logic [31:0]              ciValueB,
  output logic                     ciDone,
  output logic [31:0]              ciResult,
  output logic                     ciError,
  output logic                     busy,
  output logic [NR_UNITS-1:0]      unitStart,
  output logic [31:0]              unitValueA,
  output logic [31:0]              unitValueB,
  input  logic [NR_UNITS-1:0]      unitDone,
  input  logic [32*NR_UNITS-1:0]   unitResult
);

  localparam int SEL_W = (NR_UNITS > 1) ? $clog2(NR_UNITS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_W-1:0]     r_sel;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_hit;
  logic [SEL_W-1:0]     w_dec_sel;
  logic                 w_sel_done;
  logic [31:0]          w_sel_result;
  logic                 w_timeout;
  logic                 w_load;
  logic [NR_UNITS-1:0]  w_start_nxt;
  logic                 w_done_nxt;
  logic                 w_busy_nxt;
  logic [31:0]          w_res_nxt;
  logic                 w_err_nxt;

  ci_id_decoder #(
    .NR_UNITS (NR_UNITS),
    .UNIT_IDS (UNIT_IDS),
    .SEL_W    (SEL_W)
  ) u_decoder (
    .i_ci_n (ciN),
    .o_hit  (w_hit),
    .o_sel  (w_dec_sel)
  );

  // Only the selected unit's done/result lane is ever looked at.
  always_comb begin
    w_sel_done   = 1'b0;
    w_sel_result = '0;
    for (int k = 0; k < NR_UNITS; k++) begin
      if (r_sel == SEL_W'(k)) begin
        w_sel_done   = unitDone[k];
        w_sel_result = unitResult[32*k +: 32];
      end
    end
  end

  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == c_timeout);
  assign w_load    = (r_state == IDLE) && ciStart && w_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_cnt      <= '0;
      unitStart  <= '0;
      unitValueA <= '0;
      unitValueB <= '0;
      ciDone     <= 1'b0;
      ciResult   <= '0;
      ciError    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      unitStart <= w_start_nxt;
      ciDone    <= w_done_nxt;
      ciResult  <= w_res_nxt;
      ciError   <= w_err_nxt;
      busy      <= w_busy_nxt;
      if (w_load) begin
        r_sel      <= w_dec_sel;
        unitValueA <= ciValueA;
        unitValueB <= ciValueB;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (ciStart) w_state_nxt = w_hit ? ISSUE : RESPOND;
      end
      ISSUE: begin
        w_state_nxt = w_sel_done ? RESPOND : WAIT;
      end
      WAIT: begin
        if (w_sel_done || w_timeout) w_state_nxt = RESPOND;
      end
      RESPOND: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output registers are loaded from the state being entered, so every
  // output reflects the current state one edge after the decision.
  always_comb begin
    w_start_nxt = '0;
    w_done_nxt  = (w_state_nxt == RESPOND);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_res_nxt   = '0;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = (r_state == WAIT) ? w_cnt_inc : '0;
    if (w_load) w_start_nxt = NR_UNITS'(1) << w_dec_sel;
    if (w_state_nxt == RESPOND) begin
      if (r_state != IDLE && w_sel_done) begin
        w_res_nxt = w_sel_result;
      end else begin
        w_res_nxt = CI_ERR_RESULT;
        w_err_nxt = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ci_dispatch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ci_dispatch_sequencer
// Description : Directed self-checking bench for ci_dispatch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ci_dispatch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ciStart, start_to;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB;
  logic [3:0]  u_done, u_done_to;
  logic [127:0] unitResult;
  logic        tgt;

  logic        done_m, err_m, busy_m, done_t, err_t, busy_t;
  logic [31:0] res_m, va_m, vb_m, res_t, va_t, vb_t;
  logic [3:0]  ustart_m, ustart_t;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ci_dispatch_sequencer #(.NR_UNITS(4), .UNIT_IDS(32'h03020100), .TIMEOUT_CYCLES(255)) dut (
    .clock(clk), .reset(rst_n), .ciStart(ciStart), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB), .ciDone(done_m), .ciResult(res_m),
    .ciError(err_m), .busy(busy_m), .unitStart(ustart_m), .unitValueA(va_m),
    .unitValueB(vb_m), .unitDone(u_done), .unitResult(unitResult)
  );

  ci_dispatch_sequencer #(.NR_UNITS(4), .UNIT_IDS(32'h03020100), .TIMEOUT_CYCLES(4)) dut_to (
    .clock(clk), .reset(rst_n), .ciStart(start_to), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB), .ciDone(done_t), .ciResult(res_t),
    .ciError(err_t), .busy(busy_t), .unitStart(ustart_t), .unitValueA(va_t),
    .unitValueB(vb_t), .unitDone(u_done_to), .unitResult(unitResult)
  );

  wire        obs_done   = tgt ? done_t   : done_m;
  wire        obs_err    = tgt ? err_t    : err_m;
  wire        obs_busy   = tgt ? busy_t   : busy_m;
  wire [31:0] obs_res    = tgt ? res_t    : res_m;
  wire [31:0] obs_va     = tgt ? va_t     : va_m;
  wire [31:0] obs_vb     = tgt ? vb_t     : vb_m;
  wire [3:0]  obs_ustart = tgt ? ustart_t : ustart_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One request: cycle c=1 is the cycle right after the edge that samples ciStart.
  task automatic txn(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                     input int done_c, input logic [3:0] done_mask,
                     input int extra_c, input logic [3:0] extra_mask, input int xstart_c,
                     input int exp_done_c, input logic [31:0] exp_res, input logic exp_err,
                     input logic [3:0] exp_start, input int ncyc);
    ciN = id; ciValueA = a; ciValueB = b;
    if (tgt) start_to = 1'b1; else ciStart = 1'b1;
    @(posedge clk); #1;
    ciStart = 1'b0; start_to = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      logic [3:0] d;
      d = (c == done_c) ? done_mask : 4'b0;
      if (c == extra_c) d = d | extra_mask;
      if (tgt) u_done_to = d; else u_done = d;
      if (c == xstart_c) begin
        if (tgt) start_to = 1'b1; else ciStart = 1'b1;
      end
      check("done", 32'(obs_done), 32'(c == exp_done_c));
      check("busy", 32'(obs_busy), 32'(c <= exp_done_c));
      check("ustart", 32'(obs_ustart), (c == 1) ? 32'(exp_start) : 32'h0);
      if (c == exp_done_c) begin
        check("result", obs_res, exp_res);
        check("error", 32'(obs_err), 32'(exp_err));
      end else begin
        check("res_idle", obs_res, 32'h0);
        check("err_idle", 32'(obs_err), 32'h0);
      end
      if (exp_start != 4'b0 && c <= exp_done_c) begin
        check("valA", obs_va, a);
        check("valB", obs_vb, b);
      end
      @(posedge clk); #1;
      u_done = '0; u_done_to = '0; ciStart = 1'b0; start_to = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; ciStart = 1'b0; start_to = 1'b0; ciN = '0;
    ciValueA = '0; ciValueB = '0; u_done = '0; u_done_to = '0; tgt = 1'b0;
    unitResult = {32'hDEAD_0003, 32'h0000_000F, 32'hAAAA_0001, 32'h1234_5678};
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done_m), 32'h0);
    check("rst_busy", 32'(busy_m), 32'h0);
    check("rst_err", 32'(err_m), 32'h0);
    check("rst_res", res_m, 32'h0);
    check("rst_ustart", 32'(ustart_m), 32'h0);
    check("rst_va", va_m, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unit 2 answers in its start cycle
    txn(8'h02, 32'h0000_0011, 32'h0000_0022, 1, 4'b0100, 0, 4'b0, 0,
        2, 32'h0000_000F, 1'b0, 4'b0100, 4);
    // Unit 0 answers five cycles after start
    txn(8'h00, 32'hCAFE_0001, 32'hBEEF_0002, 6, 4'b0001, 0, 4'b0, 0,
        7, 32'h1234_5678, 1'b0, 4'b0001, 9);
    // Unmatched id
    txn(8'h7F, 32'h1, 32'h2, 0, 4'b0, 0, 4'b0, 0,
        1, 32'h0, 1'b1, 4'b0000, 3);
    // Stray done from unit 3 and a second ciStart while serving unit 0
    txn(8'h00, 32'h5555_AAAA, 32'hAAAA_5555, 4, 4'b0001, 2, 4'b1000, 3,
        5, 32'h1234_5678, 1'b0, 4'b0001, 8);

    // Timeout on the short-timeout instance, then normal service of unit 1
    tgt = 1'b1;
    txn(8'h01, 32'h0000_0101, 32'h0000_0202, 0, 4'b0, 0, 4'b0, 0,
        6, 32'h0, 1'b1, 4'b0010, 8);
    txn(8'h01, 32'h0000_0303, 32'h0000_0404, 2, 4'b0010, 0, 4'b0, 0,
        3, 32'hAAAA_0001, 1'b0, 4'b0010, 5);
    tgt = 1'b0;

    // Asynchronous reset while waiting on unit 0
    ciN = 8'h00; ciValueA = 32'h7777_0000; ciValueB = 32'h0000_7777; ciStart = 1'b1;
    @(posedge clk); #1;
    ciStart = 1'b0;
    @(posedge clk); #1;
    check("wait_busy", 32'(busy_m), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_m), 32'h0);
    check("arst_va", va_m, 32'h0);
    check("arst_vb", vb_m, 32'h0);
    check("arst_done", 32'(done_m), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    u_done = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", 32'(done_m), 32'h0);
      check("post_rst_busy", 32'(busy_m), 32'h0);
    end
    u_done = '0;
    txn(8'h00, 32'h0BAD_F00D, 32'h0000_0001, 2, 4'b0001, 0, 4'b0, 0,
        3, 32'h1234_5678, 1'b0, 4'b0001, 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
